// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the KGP-RISC data-memory responder: FSM states and
// default bus geometry.
package kgp_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the execute stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_W = kgp_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = kgp_mem_pkg::DEF_DATA_W
);

    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              memReady;
    logic              busy;
    logic              accessErr;

    modport master (
        output memRead, memWrite, addr, writeData,
        input  readData, memReady, busy, accessErr
    );

    modport slave (
        input  memRead, memWrite, addr, writeData,
        output readData, memReady, busy, accessErr
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM: one-cycle write, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, completes it after LATENCY
// cycles with a one-cycle memReady pulse, flagging illegal requests.
module data_mem_responder
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    data_mem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int CNT_W = 4;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;

    logic              commit;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_rd, eff_wr;
    logic              oor, eff_err;
    logic [DATA_W-1:0] ram_rdata;

    // With LATENCY=1 the commit happens on the acceptance edge, before the
    // latched copies exist, so the request is taken straight from the bus.
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr  = bus.addr;
            eff_wdata = bus.writeData;
            eff_rd    = bus.memRead;
            eff_wr    = bus.memWrite;
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_rd    = rd_q;
            eff_wr    = wr_q;
        end
    end

    generate
        if (ADDR_W > IDX_W + OFF_W) begin : g_oor
            assign oor = |eff_addr[ADDR_W-1:IDX_W+OFF_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    assign eff_err = (|eff_addr[OFF_W-1:0]) | oor | (eff_rd & eff_wr);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;
        rvalid_d = rvalid_q;
        commit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.memRead | bus.memWrite) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.writeData;
                    rd_d    = bus.memRead;
                    wr_d    = bus.memWrite;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            err_d    = eff_err;
            rvalid_d = eff_rd & ~eff_err;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Illegal requests never reach the array, so it is left untouched.
    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (commit & eff_wr & ~eff_err),
        .re_i    (commit & eff_rd & ~eff_err),
        .idx_i   (eff_addr[IDX_W+OFF_W-1:OFF_W]),
        .wdata_i (eff_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.readData  = rvalid_q ? ram_rdata : '0;
    assign bus.memReady  = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.accessErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table on a LATENCY=2
// instance plus hand sequences for back-to-back, mid-op reset and LATENCY=1.
module tb_data_mem_responder;

    logic clk;
    logic rstN;

    data_mem_responder_if bus ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.LATENCY(2)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            bus1.memRead = rd; bus1.memWrite = wr; bus1.addr = a; bus1.writeData = wd;
        end else begin
            bus.memRead = rd; bus.memWrite = wr; bus.addr = a; bus.writeData = wd;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus1.memReady : bus.memReady;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? bus1.busy : bus.busy;
    endfunction

    // Called one step after a rising edge with the DUT idle; returns one step
    // after the edge that leaves DONE. edges counts rising edges between the
    // acceptance edge and the first cycle memReady is seen high.
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int edges, output logic busy_acc,
                          output logic busy_after);
        drive(sel, rd, wr, a, wd);
        @(posedge clk); #1;
        busy_acc = bsy(sel);
        edges = 0;
        while (!rdy(sel) && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        rdata = sel ? bus1.readData : bus.readData;
        err   = sel ? bus1.accessErr : bus.accessErr;
        drive(sel, 1'b0, 1'b0, a, wd);
        @(posedge clk); #1;
        busy_after = bsy(sel);
        $display("[%0t] dut%0d rd=%0b wr=%0b addr=%h wdata=%h -> rdata=%h err=%0b edges=%0d",
                 $time, sel ? 1 : 2, rd, wr, a, wd, rdata, err, edges);
    endtask

    vec_t        vecs [15];
    logic [31:0] rdata;
    logic        err, busy_acc, busy_after;
    int          edges;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,          32'h0,          1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 32'h0,          1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0,          1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hCAFE_0020, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h00C0_FFEE, 32'h0,          1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          32'h0,          1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0055, 32'h0,          1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h00C0_FFEE, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0,          1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'hA5A5_A5A5, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 32'h0,          1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'h1111_2222, 1'b0};

        rstN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held for three cycles while memRead toggles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.memRead  = ~bus.memRead;
            bus1.memRead = ~bus1.memRead;
            @(negedge clk);
            check($sformatf("rst_ready_%0d", i), 32'(bus.memReady), 32'h0);
            check($sformatf("rst_busy_%0d", i), 32'(bus.busy), 32'h0);
            check($sformatf("rst_err_%0d", i), 32'(bus.accessErr), 32'h0);
            check($sformatf("rst_rdata_%0d", i), bus.readData, 32'h0);
            check($sformatf("rst1_ready_%0d", i), 32'(bus1.memReady), 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check("post_rst_ready", 32'(bus.memReady), 32'h0);

        for (int i = 0; i < 15; i++) begin
            access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   rdata, err, edges, busy_acc, busy_after);
            check($sformatf("v%0d_latency", i), 32'(edges), 32'd2);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_busy_acc", i), 32'(busy_acc), 32'h1);
            check($sformatf("v%0d_busy_after", i), 32'(busy_after), 32'h0);
            if (vecs[i].rd || vecs[i].exp_err)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Back-to-back: load held high across memReady.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        edges = 0;
        while (!bus.memReady && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("b2b_first_latency", 32'(edges), 32'd2);
        check("b2b_first_rdata", bus.readData, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("b2b_idle_busy", 32'(bus.busy), 32'h0);
        check("b2b_idle_ready", 32'(bus.memReady), 32'h0);
        @(posedge clk); #1;
        check("b2b_second_accept", 32'(bus.busy), 32'h1);
        edges = 0;
        while (!bus.memReady && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("b2b_second_latency", 32'(edges), 32'd2);
        check("b2b_second_rdata", bus.readData, 32'hDEAD_BEEF);
        $display("[%0t] dut2 back-to-back load 0x10 done", $time);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;

        // Store to 0x40 abandoned by a reset pulse while BUSY.
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h9999_9999);
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(bus.busy), 32'h1);
        #2 rstN = 1'b0;
        #1;
        check("midrst_busy_async", 32'(bus.busy), 32'h0);
        check("midrst_rdata_async", bus.readData, 32'h0);
        check("midrst_ready_async", 32'(bus.memReady), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        $display("[%0t] dut2 store 0x40 abandoned by reset", $time);
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, rdata, err, edges, busy_acc, busy_after);
        check("midrst_load_rdata", rdata, 32'h1111_2222);
        check("midrst_load_err", 32'(err), 32'h0);

        // LATENCY=1 instance: IDLE straight to DONE.
        access(1'b1, 1'b0, 1'b1, 32'h80, 32'h0BAD_F00D, rdata, err, edges, busy_acc, busy_after);
        check("l1_store_latency", 32'(edges), 32'd0);
        check("l1_store_err", 32'(err), 32'h0);
        check("l1_store_busy_after", 32'(busy_after), 32'h0);
        access(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, rdata, err, edges, busy_acc, busy_after);
        check("l1_load_latency", 32'(edges), 32'd0);
        check("l1_load_rdata", rdata, 32'h0BAD_F00D);
        check("l1_load_busy_acc", 32'(busy_acc), 32'h1);
        access(1'b1, 1'b1, 1'b0, 32'h82, 32'h0, rdata, err, edges, busy_acc, busy_after);
        check("l1_misaligned_err", 32'(err), 32'h1);
        check("l1_misaligned_rdata", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
